// File: rtl/ex_stage_md.sv
// Execute stage with three-way operand forwarding, registered EX/MEM outputs
// and an iterative RV32M multiply/divide unit that stalls the front of the pipe.
module ex_stage_md #(
  parameter int unsigned     XLEN   = 32,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      rd_i,
  input  logic [1:0]      fwd_a_sel_i,
  input  logic [1:0]      fwd_b_sel_i,
  input  logic [XLEN-1:0] ex_mem_fwd_i,
  input  logic [XLEN-1:0] mem_wb_fwd_i,
  input  logic            alumux1_sel_i,
  input  logic            alumux2_sel_i,
  input  logic [2:0]      aluop_i,
  input  logic            md_i,
  input  logic [2:0]      mdop_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;

  md_state_t           state;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     mag_b;
  logic                sign_a, sign_b, b_zero;
  logic [2:0]          op;

  logic [XLEN-1:0]     op_a, op_b, op1, op2, alu_out;
  logic                start, running;
  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [XLEN-1:0]     quo, rem, md_result;

  always_comb begin
    unique case (fwd_a_sel_i)
      2'd1:    op_a = ex_mem_fwd_i;
      2'd2:    op_a = mem_wb_fwd_i;
      default: op_a = rs1_i;
    endcase
    unique case (fwd_b_sel_i)
      2'd1:    op_b = ex_mem_fwd_i;
      2'd2:    op_b = mem_wb_fwd_i;
      default: op_b = rs2_i;
    endcase
    op1 = alumux1_sel_i ? pc_i : op_a;
    op2 = alumux2_sel_i ? op_b : imm_i;
  end

  always_comb begin
    unique case (aluop_i)
      3'b000:  alu_out = op1 + op2;
      3'b001:  alu_out = op1 << op2[CW-1:0];
      3'b010:  alu_out = $unsigned($signed(op1) >>> op2[CW-1:0]);
      3'b011:  alu_out = op1 - op2;
      3'b100:  alu_out = op1 ^ op2;
      3'b101:  alu_out = op1 >> op2[CW-1:0];
      3'b110:  alu_out = op1 | op2;
      default: alu_out = op1 & op2;
    endcase
  end

  assign start   = valid_i & md_i & ~hold_i & ~flush_i & (state == IDLE);
  assign running = (state == MUL) || (state == DIV);
  assign stall_o = hold_i | (~flush_i & (start | running));
  assign busy_o  = (state != IDLE);

  // Operands are iterated as magnitudes; signs are reapplied once in DONE.
  always_comb begin
    a_signed = mdop_i[2] ? ~mdop_i[0] : (mdop_i[1] ^ mdop_i[0]);
    b_signed = mdop_i[2] ? ~mdop_i[0] : (mdop_i[1:0] == 2'b01);
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    abs_a    = a_neg ? '0 - op_a : op_a;
    abs_b    = b_neg ? '0 - op_b : op_b;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, mag_b};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod = (sign_a ^ sign_b) ? '0 - acc : acc;
    quo  = b_zero ? '1 : ((sign_a ^ sign_b) ? '0 - acc[XLEN-1:0] : acc[XLEN-1:0]);
    rem  = sign_a ? '0 - acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op[2])                md_result = op[1] ? rem : quo;
    else if (op[1:0] == 2'b00) md_result = prod[XLEN-1:0];
    else                      md_result = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      mag_b        <= '0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      b_zero       <= 1'b0;
      op           <= '0;
      valid_o      <= 1'b0;
      result_o     <= '0;
      store_data_o <= '0;
      pc_o         <= RST_PC;
      rd_o         <= '0;
    end else if (!hold_i) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= mdop_i[2] ? DIV : MUL;
            cnt          <= '0;
            acc          <= {{XLEN{1'b0}}, abs_a};
            mag_b        <= abs_b;
            sign_a       <= a_neg;
            sign_b       <= b_neg;
            b_zero       <= (op_b == '0);
            op           <= mdop_i;
            valid_o      <= 1'b0;
            pc_o         <= pc_i;
            rd_o         <= rd_i;
            store_data_o <= op_b;
          end else if (valid_i && !md_i && !flush_i) begin
            valid_o      <= 1'b1;
            result_o     <= alu_out;
            pc_o         <= pc_i;
            rd_o         <= rd_i;
            store_data_o <= op_b;
          end else begin
            valid_o <= 1'b0;
          end
        end
        MUL, DIV: begin
          valid_o <= 1'b0;
          if (flush_i) begin
            state <= IDLE;
          end else begin
            acc <= (state == MUL) ? mul_next : div_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1)) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (flush_i) begin
            valid_o <= 1'b0;
          end else begin
            valid_o  <= 1'b1;
            result_o <= md_result;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parameterised successor to the single-cycle execute stage.
- Adds working three-way operand forwarding and a registered EX/MEM output stage.
- Adds an iterative RV32M multiply/divide unit that stalls the front of the pipe while it runs.
- Sits between the ID/EX register and the MEM stage; the hazard unit drives the forwarding selects and consumes stall_o.

Parameters:
- XLEN, 32, datapath width in bits; must be even and at least 8.
- RST_PC, 0, value loaded into pc_o on reset.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-low
- valid_i  in  1  ID/EX holds a real instruction
- pc_i  in  XLEN  instruction PC
- rs1_i, rs2_i  in  XLEN  register-file operands
- imm_i  in  XLEN  pre-selected immediate (i/s/b/u/j)
- rd_i  in  5  destination register
- fwd_a_sel_i, fwd_b_sel_i  in  2  forwarding select: 0=id_ex, 1=ex_mem, 2=mem_wb, 3=reserved (treated as id_ex)
- ex_mem_fwd_i, mem_wb_fwd_i  in  XLEN  forwarded values
- alumux1_sel_i  in  1  0=forwarded rs1, 1=pc
- alumux2_sel_i  in  1  0=imm, 1=forwarded rs2
- aluop_i  in  3  ALU op, same encoding as existing alu
- md_i  in  1  instruction is M-extension
- mdop_i  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- hold_i  in  1  downstream stall; freezes this stage
- flush_i  in  1  kill the instruction currently in EX
- stall_o  out  1  ID/EX must hold its contents
- valid_o  out  1  EX/MEM register valid
- result_o  out  XLEN  registered ALU or M result
- store_data_o  out  XLEN  registered forwarded rs2
- pc_o  out  XLEN  registered pc
- rd_o  out  5  registered rd
- busy_o  out  1  M unit not IDLE

Behaviour:
- Reset (rst=0, async): valid_o=0, result_o=0, store_data_o=0, rd_o=0, pc_o=RST_PC, FSM=IDLE, step counter=0, stall_o=0, busy_o=0.
- Forwarding: op_a/op_b are chosen combinationally by fwd_*_sel_i before the ALU muxes; store_data_o captures forwarded rs2.
- Non-M instruction (valid_i=1, md_i=0, hold_i=0): 1-cycle latency. At the next edge: result_o=alu(op1,op2), valid_o=1, pc/rd/store_data registered.
- hold_i=1: all output registers, the FSM and the counter keep their values; stall_o=1.
- flush_i=1 (without hold_i): next edge loads valid_o=0. If the FSM is busy it returns to IDLE at the same edge and the partial result is discarded. flush_i has priority over completion.
- Bubble: valid_i=0, or stall_o=1 due to the M unit, loads valid_o=0 at the next edge.
- M FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL/DIV when valid_i & md_i & !hold_i & !flush_i. At that edge the unit latches operand magnitudes, signs, and mdop, and clears the counter. stall_o=1 combinationally during the accept cycle.
  - MUL: radix-2 shift-add on a 2*XLEN product, one bit per cycle, XLEN cycles. stall_o=1.
  - DIV: restoring division, one quotient bit per cycle, XLEN cycles. stall_o=1.
  - Counter reaching XLEN-1 moves the FSM to DONE.
  - DONE: stall_o=0. The sign-corrected result is selected (low half for MUL, high half for MULH*, quotient or remainder for DIV*/REM*). It loads into result_o with valid_o=1 at the edge leaving DONE. DONE -> IDLE.
  - Total: XLEN+1 stall cycles, then the result appears one edge after DONE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: signed. The remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones; remainder = dividend. Still takes full latency.
- Signed overflow (dividend = most negative, divisor = -1): quotient = dividend, remainder = 0.
- While stall_o=1, upstream holds valid_i and all operands stable. Forwarded operand values are sampled only at the accept edge.

Test Plan:
- Reset mid-DIV (assert rst at cycle 10 of a DIV) -> all outputs reset asynchronously, FSM=IDLE, stall_o=0. After release, an ADD 3+4 gives result_o=7 one cycle later.
- ADD with fwd_a_sel=1, ex_mem_fwd_i=0x10, rs1_i=0x99, imm_i=5 -> result_o=0x15, valid_o=1 one edge later. Repeat with sel=2, mem_wb_fwd_i=0x20 -> 0x25.
- MUL 7 * 0xFFFFFFFD -> stall_o high 33 cycles, result_o=0xFFFFFFEB. MULH on the same operands -> 0xFFFFFFFF. MULHU -> 0x00000006.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- DIV 5 / 0 -> 0xFFFFFFFF. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
- flush_i at cycle 12 of a DIVU -> next edge valid_o=0, busy_o=0, stall_o=0. hold_i asserted for 3 cycles during a MUL -> completion delayed exactly 3 cycles, result unchanged.
